// File: rtl/uart_cmd_responder_pkg.sv
// Shared constants and state encoding for the UART command responder.
package uart_cmd_responder_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] OP_WRITE = 8'h57;
    localparam logic [BYTE_W-1:0] OP_READ  = 8'h52;
    localparam logic [BYTE_W-1:0] RSP_ACK  = 8'h06;
    localparam logic [BYTE_W-1:0] RSP_NAK  = 8'h15;

    typedef enum logic [1:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        RESPOND
    } resp_state_t;

    function automatic logic is_opcode(input logic [BYTE_W-1:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/uart_cmd_responder_timer.sv
// Mid-frame inactivity timer: counts cycles without a pop while a frame is open.
module uart_frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + CW'(1);
        end
    end

    // Fires on the idle cycle that brings the count up to TIMEOUT_CYCLES.
    assign expired = run && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_cmd_responder.sv
// Pops write/read command frames from the RX FIFO, executes them against a
// byte-wide register file and pushes one response byte per frame to the TX FIFO.
module uart_cmd_responder
    import uart_cmd_responder_pkg::*;
#(
    parameter int unsigned NUM_REGS       = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_W-1:0]     rx_data,
    input  logic                  rx_empty,
    output logic                  rx_rd,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  tx_wr,
    input  logic                  tx_full,
    output logic [NUM_REGS*8-1:0] regs_q,
    output logic                  busy,
    output logic                  proto_err
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    resp_state_t       state, state_d;
    logic              is_write, is_write_d;
    logic [BYTE_W-1:0] addr, addr_d;
    logic [BYTE_W-1:0] tx_data_d;
    logic              tx_wr_d, rx_rd_d, proto_err_d, busy_d;
    logic              reg_we;
    logic              tmr_clear, tmr_run, tmr_expired;
    logic [BYTE_W-1:0] regs [NUM_REGS];

    function automatic logic addr_ok(input logic [BYTE_W-1:0] a);
        return {1'b0, a} < 9'(NUM_REGS);
    endfunction

    assign tmr_clear = !((state == GET_ADDR) || (state == GET_DATA)) || rx_rd;
    assign tmr_run   = !tmr_clear;

    uart_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .run    (tmr_run),
        .expired(tmr_expired)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state;
        is_write_d  = is_write;
        addr_d      = addr;
        tx_data_d   = tx_data;
        tx_wr_d     = 1'b0;
        proto_err_d = 1'b0;
        reg_we      = 1'b0;

        unique case (state)
            IDLE: begin
                if (rx_rd) begin
                    if (is_opcode(rx_data)) begin
                        is_write_d = (rx_data == OP_WRITE);
                        state_d    = GET_ADDR;
                    end else begin
                        tx_data_d   = RSP_NAK;
                        proto_err_d = 1'b1;
                        tx_wr_d     = !tx_full;
                        state_d     = RESPOND;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_rd) begin
                    addr_d = rx_data;
                    if (is_write) begin
                        state_d = GET_DATA;
                    end else begin
                        state_d = RESPOND;
                        tx_wr_d = !tx_full;
                        if (addr_ok(rx_data)) begin
                            tx_data_d = regs[rx_data[AW-1:0]];
                        end else begin
                            tx_data_d   = RSP_NAK;
                            proto_err_d = 1'b1;
                        end
                    end
                end else if (tmr_expired) begin
                    state_d     = IDLE;
                    proto_err_d = 1'b1;
                end
            end
            GET_DATA: begin
                if (rx_rd) begin
                    state_d = RESPOND;
                    tx_wr_d = !tx_full;
                    if (addr_ok(addr)) begin
                        reg_we    = 1'b1;
                        tx_data_d = RSP_ACK;
                    end else begin
                        tx_data_d   = RSP_NAK;
                        proto_err_d = 1'b1;
                    end
                end else if (tmr_expired) begin
                    state_d     = IDLE;
                    proto_err_d = 1'b1;
                end
            end
            RESPOND: begin
                if (tx_wr) begin
                    state_d = IDLE;
                end else begin
                    tx_wr_d = !tx_full;
                end
            end
            default: state_d = IDLE;
        endcase

        // The FIFO only drains through our pops, so a non-empty flag seen now
        // still holds next cycle; skipping a cycle after each pop lets it update.
        rx_rd_d = (state_d != RESPOND) && !rx_empty && !rx_rd;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            addr      <= '0;
            tx_data   <= '0;
            tx_wr     <= 1'b0;
            rx_rd     <= 1'b0;
            proto_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            is_write  <= is_write_d;
            addr      <= addr_d;
            tx_data   <= tx_data_d;
            tx_wr     <= tx_wr_d;
            rx_rd     <= rx_rd_d;
            proto_err <= proto_err_d;
            busy      <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[addr[AW-1:0]] <= rx_data;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_q[8*g +: 8] = regs[g];
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: frame vector table plus
// backpressure, timeout, mid-frame reset and back-to-back sequences.
module tb_uart_cmd_responder;

    localparam int NREG = 16;
    localparam int TMO  = 20;
    localparam int RW   = NREG * 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_empty;
    logic          rx_rd;
    logic [7:0]    tx_data;
    logic          tx_wr;
    logic          tx_full;
    logic [RW-1:0] regs_q;
    logic          busy;
    logic          proto_err;

    uart_cmd_responder #(
        .NUM_REGS      (NREG),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rx_rd    (rx_rd),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_full  (tx_full),
        .regs_q   (regs_q),
        .busy     (busy),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         n;
        logic [7:0] rsp;
        logic       err;
    } vec_t;

    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] model [NREG];
    bit         pend_pop = 1'b0;
    bit         prev_rd  = 1'b0;
    int         pop_cnt = 0, err_cnt = 0;
    int         consec_viol = 0, empty_viol = 0, full_viol = 0;
    int         checks = 0, errors = 0;
    vec_t       vecs[12];

    function automatic void fifo_refresh();
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
    endfunction

    // FIFO model and output monitor; a pop seen this cycle retires at the next negedge.
    always @(negedge clk) begin
        if (pend_pop && rx_q.size() > 0) rx_q.delete(0);
        pend_pop = 1'b0;
        if (reset !== 1'b1) begin
            if (rx_rd === 1'b1) begin
                pop_cnt++;
                pend_pop = 1'b1;
                if (prev_rd) consec_viol++;
                if (rx_empty) empty_viol++;
            end
            if (tx_wr === 1'b1) begin
                tx_log.push_back(tx_data);
                if (tx_full) full_viol++;
            end
            if (proto_err === 1'b1) err_cnt++;
        end
        prev_rd = (rx_rd === 1'b1);
        fifo_refresh();
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_q.push_back(b);
        fifo_refresh();
    endtask

    task automatic clear_mon();
        pop_cnt = 0;
        err_cnt = 0;
        tx_log.delete();
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        int k = 0;
        while (tx_log.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (tx_log.size() < n) begin
            errors++;
            $display("FAIL %s_wait: got %0d responses expected %0d", name, tx_log.size(), n);
        end
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k = 0;
        while (pop_cnt < n && k < budget) begin
            tick(1);
            k++;
        end
        chk({name, "_pops"}, RW'(pop_cnt), RW'(n));
    endtask

    function automatic logic [RW-1:0] model_flat();
        logic [RW-1:0] v = '0;
        for (int i = 0; i < NREG; i++) v[8*i +: 8] = model[i];
        return v;
    endfunction

    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int n, input logic [7:0] rsp, input logic err, input string name);
        logic [7:0] got;
        clear_mon();
        push_rx(b0);
        if (n > 1) push_rx(b1);
        if (n > 2) push_rx(b2);
        wait_tx(1, 60, name);
        tick(4);
        got = (tx_log.size() > 0) ? tx_log[0] : 8'h00;
        if (b0 == 8'h57 && n == 3 && rsp == 8'h06) model[b1[3:0]] = b2;
        chk({name, "_rsp"},  RW'(got), RW'(rsp));
        chk({name, "_nrsp"}, RW'(tx_log.size()), RW'(1));
        chk({name, "_err"},  RW'(err_cnt), RW'(err));
        chk({name, "_pops"}, RW'(pop_cnt), RW'(n));
        chk({name, "_busy"}, RW'(busy), RW'(0));
        chk({name, "_regs"}, regs_q, model_flat());
    endtask

    initial begin
        logic [7:0] exp_b2b [6];

        vecs[0]  = '{8'h57, 8'h03, 8'hA5, 3, 8'h06, 1'b0};
        vecs[1]  = '{8'h52, 8'h03, 8'h00, 2, 8'hA5, 1'b0};
        vecs[2]  = '{8'h41, 8'h00, 8'h00, 1, 8'h15, 1'b1};
        vecs[3]  = '{8'h57, 8'h10, 8'hFF, 3, 8'h15, 1'b1};
        vecs[4]  = '{8'h52, 8'h10, 8'h00, 2, 8'h15, 1'b1};
        vecs[5]  = '{8'h57, 8'h0F, 8'h3C, 3, 8'h06, 1'b0};
        vecs[6]  = '{8'h52, 8'h0F, 8'h00, 2, 8'h3C, 1'b0};
        vecs[7]  = '{8'h52, 8'h00, 8'h00, 2, 8'h00, 1'b0};
        vecs[8]  = '{8'h57, 8'h0A, 8'h5A, 3, 8'h06, 1'b0};
        vecs[9]  = '{8'h52, 8'h0A, 8'h00, 2, 8'h5A, 1'b0};
        vecs[10] = '{8'hFF, 8'h00, 8'h00, 1, 8'h15, 1'b1};
        vecs[11] = '{8'h52, 8'h57, 8'h00, 2, 8'h15, 1'b1};
        for (int i = 0; i < NREG; i++) model[i] = 8'h00;

        reset   = 1'b1;
        tx_full = 1'b0;
        fifo_refresh();
        tick(3);
        chk("rst_regs",  regs_q, '0);
        chk("rst_busy",  RW'(busy), RW'(0));
        chk("rst_rx_rd", RW'(rx_rd), RW'(0));
        chk("rst_tx_wr", RW'(tx_wr), RW'(0));
        chk("rst_tx_data", RW'(tx_data), RW'(0));
        chk("rst_proto_err", RW'(proto_err), RW'(0));
        reset = 1'b0;
        tick(2);

        for (int i = 0; i < 12; i++) begin
            run_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].n, vecs[i].rsp, vecs[i].err,
                      $sformatf("vec%0d", i));
        end
        chk("reg3_slice", RW'(regs_q[31:24]), RW'(8'hA5));

        // Backpressure: response held while TX FIFO is full, no further pops.
        clear_mon();
        tx_full = 1'b1;
        push_rx(8'h52); push_rx(8'h00); push_rx(8'h52); push_rx(8'h01);
        tick(50);
        chk("bp_busy",  RW'(busy), RW'(1));
        chk("bp_no_tx", RW'(tx_log.size()), RW'(0));
        chk("bp_pops",  RW'(pop_cnt), RW'(2));
        chk("bp_tx_wr_low", RW'(tx_wr), RW'(0));
        tx_full = 1'b0;
        tick(1);
        chk("bp_tx_wr", RW'(tx_wr), RW'(1));
        chk("bp_tx_data", RW'(tx_data), RW'(8'h00));
        wait_tx(2, 60, "bp");
        tick(4);
        chk("bp_rsp1", RW'(tx_log.size() > 1 ? tx_log[1] : 8'hEE), RW'(model[1]));
        chk("bp_total_pops", RW'(pop_cnt), RW'(4));
        chk("bp_idle", RW'(busy), RW'(0));

        // Timeout on a write frame missing its data byte.
        clear_mon();
        push_rx(8'h57); push_rx(8'h05);
        wait_pops(2, 20, "tmo");
        tick(20);
        chk("tmo_busy_before", RW'(busy), RW'(1));
        tick(1);
        chk("tmo_busy_after", RW'(busy), RW'(0));
        chk("tmo_proto_err", RW'(proto_err), RW'(1));
        tick(5);
        chk("tmo_no_tx", RW'(tx_log.size()), RW'(0));
        chk("tmo_err_cnt", RW'(err_cnt), RW'(1));
        run_frame(8'h52, 8'h05, 8'h00, 2, 8'h00, 1'b0, "tmo_read");

        // Reset in the middle of a frame.
        run_frame(8'h57, 8'h07, 8'hA5, 3, 8'h06, 1'b0, "rst_pre");
        chk("rst_pre_reg7", RW'(regs_q[63:56]), RW'(8'hA5));
        clear_mon();
        push_rx(8'h57); push_rx(8'h07);
        wait_pops(2, 20, "rstmf");
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = 8'h00;
        tick(1);
        chk("rstmf_regs", regs_q, '0);
        chk("rstmf_busy", RW'(busy), RW'(0));
        tick(10);
        chk("rstmf_no_tx", RW'(tx_log.size()), RW'(0));
        run_frame(8'h52, 8'h07, 8'h00, 2, 8'h00, 1'b0, "rstmf_read");

        // Back-to-back frames with the RX FIFO kept non-empty.
        clear_mon();
        push_rx(8'h57); push_rx(8'h01); push_rx(8'h11);
        push_rx(8'h57); push_rx(8'h02); push_rx(8'h22);
        push_rx(8'h52); push_rx(8'h01);
        push_rx(8'h52); push_rx(8'h02);
        push_rx(8'h41);
        push_rx(8'h52); push_rx(8'h0F);
        exp_b2b = '{8'h06, 8'h06, 8'h11, 8'h22, 8'h15, 8'h00};
        model[1] = 8'h11;
        model[2] = 8'h22;
        wait_tx(6, 300, "b2b");
        tick(4);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("b2b_rsp%0d", i), RW'(tx_log.size() > i ? tx_log[i] : 8'hEE), RW'(exp_b2b[i]));
        end
        chk("b2b_nrsp", RW'(tx_log.size()), RW'(6));
        chk("b2b_pops", RW'(pop_cnt), RW'(13));
        chk("b2b_err", RW'(err_cnt), RW'(1));
        chk("b2b_regs", regs_q, model_flat());

        chk("rd_consecutive", RW'(consec_viol), RW'(0));
        chk("rd_when_empty", RW'(empty_viol), RW'(0));
        chk("wr_when_full", RW'(full_viol), RW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
